// File: rtl/triad_decoder_bank_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package   : triad_pkg                                                       |
// | Purpose   : Shared types and constants for the triad decoder bank:          |
// |             framing FSM encoding, triad geometry, skip counter width and    |
// |             the halfstrip one-hot helper.                                    |
// | Revision  : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
package triad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_B1   = 2'd1,
    ST_B0   = 2'd2
  } triad_state_t;

  localparam int TRIAD_LEN    = 3;
  localparam int HS_PER_TRIAD = 4;
  localparam int SKIP_CNT_W   = 8;

  // Halfstrip index {b1,b0} selects one of four halfstrips of a distrip.
  function automatic logic [HS_PER_TRIAD-1:0] hs_onehot(input logic b1, input logic b0);
    return {{(HS_PER_TRIAD-1){1'b0}}, 1'b1} << {b1, b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/triad_decoder_bank_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Interface : triad_decoder_bank_if                                           |
// | Purpose   : Bundles the triad inputs, comparison controls and decoded       |
// |             halfstrip / error readback of the triad decoder bank.           |
// |             master = stimulus/register side, slave = decoder bank.          |
// | Revision  : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
interface triad_decoder_bank_if
  import triad_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int PERSIST_W = 4,
  parameter int CNT_W     = 32
);
  logic [NCH-1:0]              triad;
  logic [PERSIST_W-1:0]        persist;
  logic                        compare_en;
  logic [HS_PER_TRIAD*NCH-1:0] hs_expect;
  logic                        errcnt_rst;
  logic                        latch_clr;
  logic [HS_PER_TRIAD*NCH-1:0] halfstrips;
  logic [HS_PER_TRIAD*NCH-1:0] hs_latched;
  logic [NCH-1:0]              triad_skip;
  logic                        skip_any;
  logic [CNT_W-1:0]            errcnt;
  logic [SKIP_CNT_W*NCH-1:0]   skip_cnt;

  modport master (
    output triad, persist, compare_en, hs_expect, errcnt_rst, latch_clr,
    input  halfstrips, hs_latched, triad_skip, skip_any, errcnt, skip_cnt
  );

  modport slave (
    input  triad, persist, compare_en, hs_expect, errcnt_rst, latch_clr,
    output halfstrips, hs_latched, triad_skip, skip_any, errcnt, skip_cnt
  );
endinterface
`default_nettype wire

// File: rtl/triad_decoder_bank_chan.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module    : triad_chan                                                      |
// | Purpose   : One distrip channel: 3-clock triad framing, one-hot halfstrip   |
// |             pattern with persist+1 hold, drop/skip pulse.                   |
// |             TRIAD_SKIP_CNT_EN adds an 8-bit saturating skip counter.        |
// | Revision  : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module triad_chan
  import triad_pkg::*;
#(
  parameter int PERSIST_W = 4
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  input  wire logic                    i_triad,
  input  wire logic [PERSIST_W-1:0]    i_persist,
  input  wire logic                    i_errcnt_rst,
  output logic      [HS_PER_TRIAD-1:0] o_hs,
  output logic                         o_skip,
  output logic      [SKIP_CNT_W-1:0]   o_skip_cnt
);

  triad_state_t              r_state;
  logic                      r_b1;
  logic [PERSIST_W-1:0]      r_cnt;
  logic                      r_active;
  logic [HS_PER_TRIAD-1:0]   r_hs;
  logic                      r_skip;

  logic w_done;
  logic w_accept;
  logic w_drop;

  // A triad completes in B0; it is taken when the hold is idle or on its last clock.
  assign w_done   = (r_state == ST_B0);
  assign w_accept = w_done && (!r_active || (r_cnt == '0));
  assign w_drop   = w_done && !w_accept;

  // Framing FSM, hold counter and registered pattern/skip outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_b1     <= 1'b0;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_hs     <= '0;
      r_skip   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (i_triad) r_state <= ST_B1;
        ST_B1: begin
          r_b1    <= i_triad;
          r_state <= ST_B0;
        end
        ST_B0:   r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      r_skip <= w_drop;

      if (w_accept) begin
        r_hs     <= hs_onehot(r_b1, i_triad);
        r_cnt    <= i_persist;
        r_active <= 1'b1;
      end else if (r_active) begin
        if (r_cnt == '0) begin
          r_active <= 1'b0;
          r_hs     <= '0;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign o_hs   = r_hs;
  assign o_skip = r_skip;

`ifdef TRIAD_SKIP_CNT_EN
  logic [SKIP_CNT_W-1:0] r_skip_cnt;

  // Saturating count of dropped triads; the counter clear wins over a same-cycle drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_skip_cnt <= '0;
    end else if (i_errcnt_rst) begin
      r_skip_cnt <= '0;
    end else if (w_drop && (r_skip_cnt != {SKIP_CNT_W{1'b1}})) begin
      r_skip_cnt <= r_skip_cnt + 1'b1;
    end
  end

  assign o_skip_cnt = r_skip_cnt;
`else
  logic w_unused_errcnt_rst;
  assign w_unused_errcnt_rst = i_errcnt_rst;
  assign o_skip_cnt          = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/triad_decoder_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module    : triad_decoder_bank                                              |
// | Purpose   : Bank of NCH triad decoders with sticky halfstrip latch,         |
// |             registered skip summary and saturating mismatch counter.        |
// |             TRIAD_SKIP_CNT_EN enables per-channel skip counters; otherwise  |
// |             skip_cnt reads as zero.                                         |
// | Revision  : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module triad_decoder_bank
  import triad_pkg::*;
#(
  parameter int NCH       = 8,
  parameter int PERSIST_W = 4,
  parameter int CNT_W     = 32
) (
  input  wire logic       clk,
  input  wire logic       reset,
  triad_decoder_bank_if.slave bus
);

  localparam int c_HS_W = HS_PER_TRIAD * NCH;

  logic [c_HS_W-1:0]          w_hs;
  logic [NCH-1:0]             w_skip;
  logic [SKIP_CNT_W*NCH-1:0]  w_skip_cnt;

  logic [c_HS_W-1:0]          r_latched;
  logic                       r_skip_any;
  logic [CNT_W-1:0]           r_errcnt;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    triad_chan #(
      .PERSIST_W (PERSIST_W)
    ) u_chan (
      .clk          (clk),
      .reset        (reset),
      .i_triad      (bus.triad[c]),
      .i_persist    (bus.persist),
      .i_errcnt_rst (bus.errcnt_rst),
      .o_hs         (w_hs[HS_PER_TRIAD*c +: HS_PER_TRIAD]),
      .o_skip       (w_skip[c]),
      .o_skip_cnt   (w_skip_cnt[SKIP_CNT_W*c +: SKIP_CNT_W])
    );
  end

  // Sticky halfstrip latch (clear wins) and one-clock-late skip summary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_latched  <= '0;
      r_skip_any <= 1'b0;
    end else begin
      r_latched  <= bus.latch_clr ? '0 : (r_latched | w_hs);
      r_skip_any <= |w_skip;
    end
  end

  // Saturating mismatch counter; the counter clear wins over a same-cycle mismatch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_errcnt <= '0;
    end else if (bus.errcnt_rst) begin
      r_errcnt <= '0;
    end else if (bus.compare_en && (w_hs != bus.hs_expect) &&
                 (r_errcnt != {CNT_W{1'b1}})) begin
      r_errcnt <= r_errcnt + 1'b1;
    end
  end

  assign bus.halfstrips = w_hs;
  assign bus.hs_latched = r_latched;
  assign bus.triad_skip = w_skip;
  assign bus.skip_any   = r_skip_any;
  assign bus.errcnt     = r_errcnt;
  assign bus.skip_cnt   = w_skip_cnt;

endmodule
`default_nettype wire

// File: tb/tb_triad_decoder_bank.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module    : tb_triad_decoder_bank                                           |
// | Purpose   : Directed and random stimulus for triad_decoder_bank, compared   |
// |             every clock against a timeline model (frame start times and     |
// |             pattern expiry cycles). Honours TRIAD_SKIP_CNT_EN.              |
// | Revision  : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_triad_decoder_bank;
  import triad_pkg::*;

  localparam int NCH = 8;
  localparam int PW  = 4;
  localparam int CW  = 4;
  localparam int HW  = HS_PER_TRIAD * NCH;

  logic clk = 1'b0;
  logic reset = 1'b0;

  triad_decoder_bank_if #(.NCH(NCH), .PERSIST_W(PW), .CNT_W(CW)) bus ();

  triad_decoder_bank #(.NCH(NCH), .PERSIST_W(PW), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #12 clk = ~clk;

  // stimulus values for the current cycle
  logic [NCH-1:0] v_triad;
  logic [PW-1:0]  v_persist;
  logic           v_compare_en;
  logic [HW-1:0]  v_hs_expect;
  logic           v_errcnt_rst;
  logic           v_latch_clr;

  // timeline model
  int             cyc;
  int             end_cyc [NCH];   // last cycle the pattern is visible
  logic [3:0]     pat     [NCH];
  int             fstart  [NCH];   // input cycle of the frame start bit, -1 if none
  logic           b1v     [NCH];
  int             skip_at [NCH];   // output cycle of the last drop pulse
  logic [7:0]     m_scnt  [NCH];
  logic [HW-1:0]  m_lat;
  logic [CW-1:0]  m_err;
  logic           m_skip_any;

  int checks = 0;
  int errors = 0;

  function automatic logic [HW-1:0] exp_hs(input int t);
    logic [HW-1:0] r = '0;
    for (int c = 0; c < NCH; c++)
      if (t <= end_cyc[c]) r[4*c +: 4] = pat[c];
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_skip(input int t);
    logic [NCH-1:0] r = '0;
    for (int c = 0; c < NCH; c++) r[c] = (skip_at[c] == t);
    return r;
  endfunction

  function automatic logic [63:0] exp_scnt();
    logic [63:0] r = '0;
    for (int c = 0; c < NCH; c++) r[8*c +: 8] = m_scnt[c];
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      end_cyc[c] = -1;
      pat[c]     = '0;
      fstart[c]  = -1;
      b1v[c]     = 1'b0;
      skip_at[c] = -1;
      m_scnt[c]  = '0;
    end
    m_lat      = '0;
    m_err      = '0;
    m_skip_any = 1'b0;
  endtask

  task automatic idle_inputs();
    v_triad      = '0;
    v_persist    = '0;
    v_compare_en = 1'b0;
    v_hs_expect  = '0;
    v_errcnt_rst = 1'b0;
    v_latch_clr  = 1'b0;
  endtask

  task automatic apply_inputs();
    bus.triad      = v_triad;
    bus.persist    = v_persist;
    bus.compare_en = v_compare_en;
    bus.hs_expect  = v_hs_expect;
    bus.errcnt_rst = v_errcnt_rst;
    bus.latch_clr  = v_latch_clr;
  endtask

  // Called #1 after a rising edge: check this cycle, drive it, advance the model.
  task automatic step();
    logic [HW-1:0]  h;
    logic [NCH-1:0] sk;
    int             k;
    h  = exp_hs(cyc);
    sk = exp_skip(cyc);
    check("halfstrips", 64'(bus.halfstrips), 64'(h));
    check("hs_latched", 64'(bus.hs_latched), 64'(m_lat));
    check("triad_skip", 64'(bus.triad_skip), 64'(sk));
    check("skip_any",   64'(bus.skip_any),   64'(m_skip_any));
    check("errcnt",     64'(bus.errcnt),     64'(m_err));
    check("skip_cnt",   64'(bus.skip_cnt),   exp_scnt());
    apply_inputs();
    k = cyc + 1;
    for (int c = 0; c < NCH; c++) begin
      if (fstart[c] >= 0 && cyc == fstart[c] + 1) begin
        b1v[c] = v_triad[c];
      end else if (fstart[c] >= 0 && cyc == fstart[c] + TRIAD_LEN - 1) begin
        if (k > end_cyc[c]) begin
          pat[c]     = 4'(1 << {b1v[c], v_triad[c]});
          end_cyc[c] = k + int'(v_persist);
        end else begin
          skip_at[c] = k;
        end
        fstart[c] = -1;
      end else if (fstart[c] < 0 && v_triad[c]) begin
        fstart[c] = cyc;
      end
`ifdef TRIAD_SKIP_CNT_EN
      if (v_errcnt_rst) m_scnt[c] = '0;
      else if (skip_at[c] == k && m_scnt[c] != 8'hFF) m_scnt[c] = m_scnt[c] + 8'd1;
`endif
    end
    m_skip_any = |sk;
    m_lat      = v_latch_clr ? '0 : (m_lat | h);
    if (v_errcnt_rst) m_err = '0;
    else if (v_compare_en && h != v_hs_expect && m_err != '1) m_err = m_err + 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // One full triad on channel ch: start bit, then b1, then b0.
  task automatic send(input int ch, input logic b1, input logic b0);
    v_triad = '0; v_triad[ch] = 1'b1; step();
    v_triad = '0; v_triad[ch] = b1;   step();
    v_triad = '0; v_triad[ch] = b0;   step();
    v_triad = '0;
  endtask

  // Asynchronous reset asserted mid-cycle, outputs must clear at once.
  task automatic do_reset();
    idle_inputs();
    apply_inputs();
    reset = 1'b1;
    #1;
    check("rst_halfstrips", 64'(bus.halfstrips), 64'd0);
    check("rst_hs_latched", 64'(bus.hs_latched), 64'd0);
    check("rst_triad_skip", 64'(bus.triad_skip), 64'd0);
    check("rst_skip_any",   64'(bus.skip_any),   64'd0);
    check("rst_errcnt",     64'(bus.errcnt),     64'd0);
    check("rst_skip_cnt",   64'(bus.skip_cnt),   64'd0);
    @(posedge clk);
    #1;
    cyc++;
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    cyc = 0;
    idle_inputs();
    model_clear();
    #1;
    do_reset();

    // one hit, persist 3 -> bit 10 for 4 clocks
    v_persist = 4'd3;
    send(2, 1'b1, 1'b0);
    idle(7);

    // second triad while hold busy is dropped
    v_persist = 4'd5;
    send(0, 1'b0, 1'b1);
    send(0, 1'b1, 1'b1);
    idle(8);

    // second triad lands on the last hold clock and replaces with no gap
    v_persist = 4'd2;
    send(0, 1'b0, 1'b0);
    send(0, 1'b1, 1'b1);
    idle(6);

    // mismatch counting and saturation
    v_errcnt_rst = 1'b1; step(); v_errcnt_rst = 1'b0;
    v_compare_en = 1'b1;
    v_hs_expect  = '0;
    v_persist    = 4'd3;
    send(1, 1'b0, 1'b1);
    idle(8);
    check("errcnt_four", 64'(bus.errcnt), 64'd4);
    v_hs_expect = '1;
    idle(20);
    check("errcnt_sat", 64'(bus.errcnt), 64'd15);
    v_compare_en = 1'b0;
    v_hs_expect  = '0;
    v_errcnt_rst = 1'b1; step(); v_errcnt_rst = 1'b0;

    // latch clear collides with a one-clock hit, later hit sticks
    v_persist = 4'd0;
    send(3, 1'b1, 1'b1);
    v_latch_clr = 1'b1; step(); v_latch_clr = 1'b0;
    idle(2);
    send(3, 1'b0, 1'b1);
    idle(4);
    check("latched_bit13", 64'(bus.hs_latched[13]), 64'd1);
    check("latched_bit15", 64'(bus.hs_latched[15]), 64'd0);

    // reset at the B1 clock, then a fresh triad
    v_persist = 4'd1;
    v_triad = '0; v_triad[4] = 1'b1; step();
    v_triad[4] = 1'b1;
    apply_inputs();
    do_reset();
    v_persist = 4'd1;
    idle(2);
    send(4, 1'b1, 1'b0);
    idle(5);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < NCH; c++) v_triad[c] = ($urandom_range(3) == 0);
      v_persist    = PW'($urandom_range(15));
      v_compare_en = 1'($urandom_range(1));
      v_hs_expect  = ($urandom_range(1) == 1) ? '0 : HW'($urandom);
      v_errcnt_rst = ($urandom_range(15) == 0);
      v_latch_clr  = ($urandom_range(7) == 0);
      step();
    end
    idle_inputs();
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
